// File: rtl/lcd_spi_pkg.sv
// Shared constants and types for the LCD SPI responder (display-controller model).
package lcd_spi_pkg;

    localparam int C_DEF_COLS       = 84;
    localparam int C_DEF_ROWS       = 6;
    localparam int C_DEF_FIFO_DEPTH = 4;

    // Command byte with bit 7 set loads the X cursor from bits [6:0].
    localparam logic [7:0] C_CMD_SETX_MASK   = 8'h80;
    // Command byte 01_000_yyy loads the Y cursor from bits [2:0].
    localparam logic [1:0] C_CMD_SETY_PREFIX = 2'b01;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } lcd_byte_t;

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronises the pins, finds sck rising edges and
// assembles MSB-first bytes, flagging each complete byte with a one-cycle pulse.
module spi_byte_rx
    import lcd_spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       csn,
    input  logic       sck,
    input  logic       mosi,
    input  logic       dc,
    output logic       byte_done,
    output logic [7:0] rx_data,
    output logic       rx_dc
);

    logic [1:0] csn_sync_r;
    logic [1:0] sck_sync_r;
    logic [1:0] mosi_sync_r;
    logic [1:0] dc_sync_r;
    logic       sck_d_r;
    logic       csn_q_s;
    logic       sck_rise_s;
    rx_state_t  state_r;
    rx_state_t  next_state_s;
    logic [6:0] shift_r;
    logic [2:0] cnt_r;
    logic       done_r;
    logic [7:0] data_r;
    logic       dc_r;

    assign csn_q_s    = csn_sync_r[1];
    assign sck_rise_s = sck_sync_r[1] & ~sck_d_r;

    assign byte_done = done_r;
    assign rx_data   = data_r;
    assign rx_dc     = dc_r;

    // Two-flop synchronisers on every SPI pin plus the sck edge-detect delay flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csn_sync_r  <= 2'b11;
            sck_sync_r  <= 2'b00;
            mosi_sync_r <= 2'b00;
            dc_sync_r   <= 2'b00;
            sck_d_r     <= 1'b0;
        end else begin
            csn_sync_r  <= {csn_sync_r[0], csn};
            sck_sync_r  <= {sck_sync_r[0], sck};
            mosi_sync_r <= {mosi_sync_r[0], mosi};
            dc_sync_r   <= {dc_sync_r[0], dc};
            sck_d_r     <= sck_sync_r[1];
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RX_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state follows the synchronised chip select.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            RX_IDLE: begin
                if (!csn_q_s) begin
                    next_state_s = RX_SHIFT;
                end else begin
                    next_state_s = RX_IDLE;
                end
            end
            RX_SHIFT: begin
                if (csn_q_s) begin
                    next_state_s = RX_IDLE;
                end else begin
                    next_state_s = RX_SHIFT;
                end
            end
            default: next_state_s = RX_IDLE;
        endcase
    end

    // Shift register and bit counter; a deselect mid-byte drops the partial byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= 7'd0;
            cnt_r   <= 3'd0;
            done_r  <= 1'b0;
            data_r  <= 8'd0;
            dc_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (next_state_s == RX_SHIFT) begin
                if (sck_rise_s) begin
                    shift_r <= {shift_r[5:0], mosi_sync_r[1]};
                    if (cnt_r == 3'd7) begin
                        cnt_r  <= 3'd0;
                        done_r <= 1'b1;
                        data_r <= {shift_r, mosi_sync_r[1]};
                        dc_r   <= dc_sync_r[1];
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
            end else begin
                cnt_r <= 3'd0;
            end
        end
    end

endmodule

// File: rtl/lcd_spi_responder.sv
// LCD SPI responder: data bytes become frame-buffer writes at the cursor,
// X/Y commands move the cursor, every other command goes into a small FIFO.
module lcd_spi_responder
    import lcd_spi_pkg::*;
#(
    parameter int C_COLS       = C_DEF_COLS,
    parameter int C_ROWS       = C_DEF_ROWS,
    parameter int C_FIFO_DEPTH = C_DEF_FIFO_DEPTH
) (
    input  logic       Bus2IP_Clk,
    input  logic       Bus2IP_Resetn,
    input  logic       lcd_csn,
    input  logic       sck,
    input  logic       mosi,
    input  logic       lcd_dc,
    output logic       fb_we,
    output logic [8:0] fb_addr,
    output logic [7:0] fb_data,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    input  logic       cmd_ready,
    output logic       ovf
);

    localparam int C_PTR_W = $clog2(C_FIFO_DEPTH);
    localparam logic [C_PTR_W:0]   C_FULL    = C_FIFO_DEPTH[C_PTR_W:0];
    localparam logic [C_PTR_W-1:0] C_PTR_ONE = (C_PTR_W)'(1);
    localparam logic [C_PTR_W:0]   C_CNT_ONE = (C_PTR_W + 1)'(1);

    logic        rx_done_s;
    logic [7:0]  rx_data_s;
    logic        rx_dc_s;
    lcd_byte_t   rx_s;

    logic [6:0]  x_r;
    logic [2:0]  y_r;
    logic [8:0]  wr_addr_s;
    logic        x_last_s;
    logic        y_last_s;
    logic        setx_ok_s;
    logic        sety_ok_s;
    logic        push_s;

    logic        fb_we_r;
    logic [8:0]  fb_addr_r;
    logic [7:0]  fb_data_r;

    logic [7:0]         mem_r [C_FIFO_DEPTH];
    logic [C_PTR_W-1:0] wr_ptr_r;
    logic [C_PTR_W-1:0] rd_ptr_r;
    logic [C_PTR_W:0]   count_r;
    logic               ovf_r;
    logic               full_s;
    logic               pop_s;
    logic               push_ok_s;

    spi_byte_rx u_rx (
        .clk       (Bus2IP_Clk),
        .rst_n     (Bus2IP_Resetn),
        .csn       (lcd_csn),
        .sck       (sck),
        .mosi      (mosi),
        .dc        (lcd_dc),
        .byte_done (rx_done_s),
        .rx_data   (rx_data_s),
        .rx_dc     (rx_dc_s)
    );

    assign rx_s      = {rx_dc_s, rx_data_s};
    assign wr_addr_s = ({6'd0, y_r} * 9'(C_COLS)) + {2'd0, x_r};
    assign x_last_s  = ({25'd0, x_r} == 32'(C_COLS - 1));
    assign y_last_s  = ({29'd0, y_r} == 32'(C_ROWS - 1));

    // Classify a received command byte: X set, Y set, or generic FIFO command.
    always_comb begin
        setx_ok_s = 1'b0;
        sety_ok_s = 1'b0;
        push_s    = 1'b0;
        if (rx_done_s && !rx_s.dc) begin
            if ((rx_s.data & C_CMD_SETX_MASK) != 8'h00) begin
                // Out-of-range X values are silently ignored, never queued.
                setx_ok_s = ({25'd0, rx_s.data[6:0]} < 32'(C_COLS));
            end else if ((rx_s.data[7:6] == C_CMD_SETY_PREFIX) &&
                         (rx_s.data[5:3] == 3'b000) &&
                         ({29'd0, rx_s.data[2:0]} < 32'(C_ROWS))) begin
                sety_ok_s = 1'b1;
            end else begin
                push_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Frame-buffer write port and cursor; cursor advances after every data byte.
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            fb_we_r   <= 1'b0;
            fb_addr_r <= 9'd0;
            fb_data_r <= 8'd0;
            x_r       <= 7'd0;
            y_r       <= 3'd0;
        end else begin
            fb_we_r <= 1'b0;
            if (rx_done_s && rx_s.dc) begin
                fb_we_r   <= 1'b1;
                fb_addr_r <= wr_addr_s;
                fb_data_r <= rx_s.data;
                if (x_last_s) begin
                    x_r <= 7'd0;
                    if (y_last_s) begin
                        y_r <= 3'd0;
                    end else begin
                        y_r <= y_r + 3'd1;
                    end
                end else begin
                    x_r <= x_r + 7'd1;
                end
            end else if (setx_ok_s) begin
                x_r <= rx_s.data[6:0];
            end else if (sety_ok_s) begin
                y_r <= rx_s.data[2:0];
            end
        end
    end

    assign full_s    = (count_r == C_FULL);
    assign pop_s     = cmd_valid && cmd_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign push_ok_s = push_s && (!full_s || pop_s);

    // Command FIFO storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            for (int i = 0; i < C_FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'd0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ovf_r    <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= rx_s.data;
                wr_ptr_r        <= wr_ptr_r + C_PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + C_PTR_ONE;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + C_CNT_ONE;
                2'b01:   count_r <= count_r - C_CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (push_s && !push_ok_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign fb_we     = fb_we_r;
    assign fb_addr   = fb_addr_r;
    assign fb_data   = fb_data_r;
    assign cmd_valid = (count_r != '0);
    assign cmd_byte  = mem_r[rd_ptr_r];
    assign ovf       = ovf_r;

endmodule

// File: doc/lcd_spi_responder.md
Name: lcd_spi_responder

Overview:
- SPI slave that receives the LCD command/data byte stream produced by the LCD SPI master, mirroring a PCD8544-style controller. Used as the on-chip display model and bench responder.
- Deserialises MOSI bytes and splits them by the D/C line:
  - data bytes become frame-buffer writes with auto-incrementing address;
  - X/Y address commands update an internal cursor;
  - all other commands are queued in a small FIFO for a downstream consumer.

Parameters:
- C_COLS, 84, number of columns (X range 0..C_COLS-1).
- C_ROWS, 6, number of 8-pixel banks (Y range 0..C_ROWS-1).
- C_FIFO_DEPTH, 4, depth of the command FIFO; power of two, minimum 2.

Ports:
- Bus2IP_Clk  in  1  system clock; all logic on its rising edge.
- Bus2IP_Resetn  in  1  asynchronous active-low reset.
- lcd_csn  in  1  SPI chip select, active low, asynchronous to the clock.
- sck  in  1  SPI clock, mode 0, asynchronous; maximum frequency is Bus2IP_Clk/4.
- mosi  in  1  SPI data, MSB first.
- lcd_dc  in  1  1 = data byte, 0 = command byte; must be stable during bit 0.
- fb_we  out  1  frame-buffer write strobe, one-cycle pulse.
- fb_addr  out  9  write address, y*C_COLS+x.
- fb_data  out  8  write data byte.
- cmd_valid  out  1  command FIFO not empty.
- cmd_byte  out  8  head-of-FIFO command byte.
- cmd_ready  in  1  consumer pops the FIFO head when cmd_valid && cmd_ready.
- ovf  out  1  sticky flag; set when a command is dropped because the FIFO is full.

Behaviour:
- Reset (Bus2IP_Resetn low, asynchronous) clears:
  - fb_we=0, fb_addr=0, fb_data=0;
  - cmd_valid=0, cmd_byte=0, ovf=0;
  - cursor x=0, y=0; bit counter=0; FIFO empty.
- Reset applied mid-byte discards the partial byte.
- Input synchronisation:
  - lcd_csn, sck, mosi and lcd_dc each pass through 2 flip-flops.
  - A rising edge of sck is detected on the synchronised signal (sck_d=0, sck_q=1).
- Shift receiver, two states:
  - IDLE: synchronised csn high; bit counter held at 0.
  - SHIFT: csn low. On each detected sck rise, shift mosi into a byte register (MSB first) and increment the bit counter.
  - On the 8th rise: produce a one-cycle byte_done pulse carrying the byte and the synchronised dc value; bit counter returns to 0.
  - csn rising while in SHIFT with counter 1..7: partial byte discarded, return to IDLE, no byte_done.
  - Consecutive bytes within one csn-low period are supported.
- Decode, in the cycle after byte_done:
  - dc=1, data byte:
    - fb_we=1, fb_data=byte, fb_addr=y*C_COLS+x.
    - Then x increments. When x reaches C_COLS-1 it wraps to 0 and y increments; y wraps from C_ROWS-1 to 0.
  - dc=0, byte[7]=1: set X to byte[6:0] if it is < C_COLS; otherwise ignored. Nothing enters the FIFO.
  - dc=0, byte[7:6]=01: set Y to byte[2:0] if it is < C_ROWS and byte[5:3]=0; otherwise the byte is queued as a generic command.
  - Any other command byte: pushed into the FIFO.
- Latency: last sck rise at the pins → fb_we or FIFO push 4 clock cycles later (2 sync + 1 edge detect + 1 decode).
- FIFO behaviour:
  - First-word-fall-through; cmd_byte is valid whenever cmd_valid=1.
  - Push when full: byte dropped, ovf set. ovf stays set until reset.
  - Simultaneous push and pop when full: the pop frees a slot, the push is accepted, no overflow.
  - Simultaneous push and pop when empty: the byte is written; cmd_valid rises next cycle (no bypass).
- fb_we is never asserted for command bytes. Address-setting commands do not generate fb_we.

Decomposition:
- Package lcd_spi_pkg holds:
  - C_CMD_SETX_MASK=8'h80;
  - C_CMD_SETY_PREFIX=2'b01;
  - default C_COLS and C_ROWS;
  - the byte-with-dc struct {dc, data[7:0]}.
- Sub-module spi_byte_rx: synchronisers, edge detect, shift register and bit counter. Outputs byte_done, byte, dc.
- The FIFO and decode logic stay in the top module.

Test Plan:
- Reset, then send dc=1 bytes 0xAA and 0x55 in one csn frame → fb_we pulses with addr 0 / data 0xAA, then addr 1 / data 0x55.
- Send command 0x85, then command 0x42, then data 0x0F → fb_addr = 2*84+5 = 173, fb_data=0x0F. No FIFO entries.
- Cursor at x=83, y=5 (commands 0xD3, 0x45), then send 2 data bytes → writes to addr 503, then addr 0.
- Send commands 0x21, 0x0C, 0x20, 0x13, 0x07 with cmd_ready=0 (depth 4) → first four readable in order, 0x07 dropped, ovf=1. Pop with cmd_ready=1 → cmd_valid falls after 4 pops.
- Raise csn after 5 bits, then send full data byte 0x3C → single fb_we carrying data 0x3C; no spurious write.
- Assert reset mid-byte and mid-FIFO-occupancy → all outputs return to 0 immediately (asynchronously); the next byte starts at bit 7 and writes addr 0.
